// File: rtl/operand_stage.sv
// Operand stage: decodes the raw instruction, selects forwarded register operands and
// immediates, and registers them behind a valid/ready handshake with a load-use stall.
module operand_stage #(
    parameter int XLEN   = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] reg1_data,
    input  logic [XLEN-1:0] reg2_data,
    input  logic            exm_we,
    input  logic [4:0]      exm_rd,
    input  logic [XLEN-1:0] exm_data,
    input  logic            mwb_we,
    input  logic [4:0]      mwb_rd,
    input  logic [XLEN-1:0] mwb_data,
    input  logic            flush,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] operand1,
    output logic [XLEN-1:0] operand2,
    output logic [XLEN-1:0] s_data,
    output logic [4:0]      rd_out,
    output logic [6:0]      op_out,
    output logic [XLEN-1:0] pc_out,
    output logic            illegal
);
    // state      | meaning
    // RUN        | normal issue, capture whenever the handshake allows
    // LOAD_STALL | one bubble while the producing load moves ahead

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic {RUN, LOAD_STALL} state_t;
    state_t state, state_nxt;

    logic [6:0] op;
    logic [4:0] rs1, rs2;
    logic [XLEN-1:0] rs1v, rs2v;
    logic [XLEN-1:0] op1_nxt, op2_nxt, sd_nxt;
    logic [4:0] rd_nxt;
    logic ill_nxt, use1, use2, hazard, capture;
    logic signed [11:0] imm_i, imm_s;
    logic signed [20:0] imm_j;
    logic signed [31:0] imm_u;
    logic unused_ok;

    assign op    = instr[6:0];
    assign rs1   = instr[19:15];
    assign rs2   = instr[24:20];
    assign imm_i = instr[31:20];
    assign imm_s = {instr[31:25], instr[11:7]};
    assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign unused_ok = ^instr[14:12];

    // EX/MEM has priority over MEM/WB; x0 never forwards
    always_comb begin
        rs1v = reg1_data;
        if (rs1 == 5'd0) rs1v = '0;
        else if (FWD_EN && exm_we && exm_rd == rs1) rs1v = exm_data;
        else if (FWD_EN && mwb_we && mwb_rd == rs1) rs1v = mwb_data;
    end

    always_comb begin
        rs2v = reg2_data;
        if (rs2 == 5'd0) rs2v = '0;
        else if (FWD_EN && exm_we && exm_rd == rs2) rs2v = exm_data;
        else if (FWD_EN && mwb_we && mwb_rd == rs2) rs2v = mwb_data;
    end

    always_comb begin
        op1_nxt = '0;
        op2_nxt = '0;
        sd_nxt  = '0;
        rd_nxt  = '0;
        ill_nxt = 1'b0;
        use1    = 1'b0;
        use2    = 1'b0;
        case (op)
            OP_R: begin
                op1_nxt = rs1v; op2_nxt = rs2v; rd_nxt = instr[11:7];
                use1 = 1'b1; use2 = 1'b1;
            end
            OP_B: begin
                op1_nxt = rs1v; op2_nxt = rs2v;
                use1 = 1'b1; use2 = 1'b1;
            end
            OP_IMM, OP_LOAD: begin
                op1_nxt = rs1v; op2_nxt = XLEN'(imm_i); rd_nxt = instr[11:7];
                use1 = 1'b1;
            end
            OP_JALR: begin
                op1_nxt = rs1v; op2_nxt = XLEN'(imm_i); rd_nxt = instr[11:7];
                sd_nxt = pc + XLEN'(4);
                use1 = 1'b1;
            end
            OP_S: begin
                op1_nxt = rs1v; op2_nxt = XLEN'(imm_s); sd_nxt = rs2v;
                use1 = 1'b1; use2 = 1'b1;
            end
            OP_JAL: begin
                op1_nxt = pc; op2_nxt = XLEN'(4); sd_nxt = XLEN'(imm_j);
                rd_nxt = instr[11:7];
            end
            OP_LUI: begin
                op2_nxt = XLEN'(imm_u); rd_nxt = instr[11:7];
            end
            OP_AUIPC: begin
                op1_nxt = pc; op2_nxt = XLEN'(imm_u); rd_nxt = instr[11:7];
            end
            default: ill_nxt = 1'b1;
        endcase
    end

    // the issued load is leaving now, but its data is not yet forwardable
    assign hazard = in_valid && out_valid && out_ready && op_out == OP_LOAD
                    && rd_out != 5'd0
                    && ((use1 && rs1 == rd_out) || (use2 && rs2 == rd_out));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:        if (!flush && hazard) state_nxt = LOAD_STALL;
            LOAD_STALL: state_nxt = RUN;
            default:    state_nxt = RUN;
        endcase
        if (flush) state_nxt = RUN;
    end

    always_comb begin
        in_ready = 1'b0;
        if (state == RUN) in_ready = (!out_valid || out_ready) && !hazard;
        capture = in_valid && in_ready && !flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            operand1  <= '0;
            operand2  <= '0;
            s_data    <= '0;
            rd_out    <= '0;
            op_out    <= '0;
            pc_out    <= '0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            operand1  <= op1_nxt;
            operand2  <= op2_nxt;
            s_data    <= sd_nxt;
            rd_out    <= rd_nxt;
            op_out    <= op;
            pc_out    <= pc;
            illegal   <= ill_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_operand_stage.sv
// Randomised bench for operand_stage with an architectural reference model and a few
// hand-computed directed scenarios.
module tb_operand_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] instr, pc, reg1_data, reg2_data;
    logic        exm_we, mwb_we;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_data, mwb_data;
    logic        flush, out_ready, out_valid, illegal;
    logic [31:0] operand1, operand2, s_data, pc_out;
    logic [4:0]  rd_out;
    logic [6:0]  op_out;

    int checks = 0;
    int errors = 0;

    operand_stage #(.XLEN(32), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .reg1_data(reg1_data), .reg2_data(reg2_data),
        .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_we(mwb_we), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
        .operand1(operand1), .operand2(operand2), .s_data(s_data),
        .rd_out(rd_out), .op_out(op_out), .pc_out(pc_out), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op1, op2, sd, pc;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic        ill;
    } exp_t;

    exp_t m_out;
    bit   m_valid;
    bit   m_stall;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] src_val(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 0) return 32'd0;
        if (exm_we && exm_rd == rs) return exm_data;
        if (mwb_we && mwb_rd == rs) return mwb_data;
        return rf;
    endfunction

    function automatic int sx(input int val, input int bits);
        return (val << (32 - bits)) >>> (32 - bits);
    endfunction

    function automatic exp_t predict();
        exp_t e;
        logic [31:0] a, b;
        int ii, is, ij, iu;
        a  = src_val(instr[19:15], reg1_data);
        b  = src_val(instr[24:20], reg2_data);
        ii = sx(int'(instr[31:20]), 12);
        is = sx(int'({instr[31:25], instr[11:7]}), 12);
        ij = sx(int'({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}), 21);
        iu = int'(instr[31:12]) * 4096;
        e = '{op1: 0, op2: 0, sd: 0, pc: pc, rd: instr[11:7], op: instr[6:0], ill: 0};
        case (instr[6:0])
            7'h33:        begin e.op1 = a; e.op2 = b; end
            7'h63:        begin e.op1 = a; e.op2 = b; e.rd = 0; end
            7'h13, 7'h03: begin e.op1 = a; e.op2 = ii; end
            7'h67:        begin e.op1 = a; e.op2 = ii; e.sd = pc + 4; end
            7'h23:        begin e.op1 = a; e.op2 = is; e.sd = b; e.rd = 0; end
            7'h6F:        begin e.op1 = pc; e.op2 = 4; e.sd = ij; end
            7'h37:        e.op2 = iu;
            7'h17:        begin e.op1 = pc; e.op2 = iu; end
            default:      begin e.ill = 1; e.rd = 0; end
        endcase
        return e;
    endfunction

    function automatic bit reads_reg(input logic [4:0] r);
        logic [6:0] o;
        bit u1, u2;
        o  = instr[6:0];
        u1 = (o == 7'h33 || o == 7'h63 || o == 7'h23 || o == 7'h13 || o == 7'h03 || o == 7'h67);
        u2 = (o == 7'h33 || o == 7'h63 || o == 7'h23);
        return r != 0 && ((u1 && instr[19:15] == r) || (u2 && instr[24:20] == r));
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_stall = 0;
        m_out   = '{op1: 0, op2: 0, sd: 0, pc: 0, rd: 0, op: 0, ill: 0};
    endtask

    // one clock: check the handshake before the edge, advance the model, check registers after
    task automatic step();
        bit haz, rdy, cap;
        exp_t e;
        #1;
        haz = in_valid && m_valid && out_ready && m_out.op == 7'h03 && reads_reg(m_out.rd);
        rdy = !m_stall && (!m_valid || out_ready) && !haz;
        chk("in_ready", in_ready, rdy);
        cap = in_valid && rdy && !flush;
        e = predict();
        @(posedge clk);
        m_stall = !flush && haz;
        if (flush)          m_valid = 0;
        else if (cap)       begin m_valid = 1; m_out = e; end
        else if (out_ready) m_valid = 0;
        #1;
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("operand1", operand1, m_out.op1);
            chk("operand2", operand2, m_out.op2);
            chk("s_data", s_data, m_out.sd);
            chk("rd_out", rd_out, m_out.rd);
            chk("op_out", op_out, m_out.op);
            chk("pc_out", pc_out, m_out.pc);
            chk("illegal", illegal, m_out.ill);
        end
    endtask

    task automatic offer(input logic v, input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] r1, input logic [31:0] r2);
        in_valid = v; instr = ins; pc = p; reg1_data = r1; reg2_data = r2;
        exm_we = 0; exm_rd = 0; exm_data = 0; mwb_we = 0; mwb_rd = 0; mwb_data = 0;
        flush = 0; out_ready = 1;
    endtask

    localparam logic [6:0] OPS [10] = '{7'h33, 7'h63, 7'h13, 7'h03, 7'h67,
                                        7'h23, 7'h6F, 7'h37, 7'h17, 7'h7F};

    initial begin
        rst_n = 0;
        offer(0, 32'h0, 32'h0, 32'h0, 32'h0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset operand1", operand1, 0);
        chk("reset operand2", operand2, 0);
        chk("reset s_data", s_data, 0);
        chk("reset rd_out", rd_out, 0);
        chk("reset op_out", op_out, 0);
        chk("reset pc_out", pc_out, 0);
        chk("reset illegal", illegal, 0);
        #2 rst_n = 1;

        // ADDI x1,x2,-1
        offer(1, 32'hFFF10093, 32'h40, 32'd5, 32'd0);
        step();
        chk("addi operand1", operand1, 32'd5);
        chk("addi operand2", operand2, 32'hFFFFFFFF);
        chk("addi rd_out", rd_out, 5'd1);

        // ADD x3,x1,x1 with both forwarding paths matching
        offer(1, 32'h001081B3, 32'h44, 32'd1, 32'd1);
        exm_we = 1; exm_rd = 1; exm_data = 32'd7; mwb_we = 1; mwb_rd = 1; mwb_data = 32'd9;
        step();
        chk("fwd operand1", operand1, 32'd7);
        chk("fwd operand2", operand2, 32'd7);

        // LW x5,0(x0) then dependent ADD x6,x5,x5
        offer(1, 32'h00002283, 32'h48, 32'd0, 32'd0);
        step();
        offer(1, 32'h00528333, 32'h4C, 32'h111, 32'h111);
        #1 chk("hazard in_ready", in_ready, 0);
        step();
        chk("bubble out_valid", out_valid, 0);
        #1 chk("stall in_ready", in_ready, 0);
        step();
        mwb_we = 1; mwb_rd = 5; mwb_data = 32'h55;
        step();
        chk("after stall out_valid", out_valid, 1);
        chk("after stall operand1", operand1, 32'h55);

        // backpressure hold, then flush
        offer(1, 32'hFFF10093, 32'h50, 32'd5, 32'd0);
        step();
        offer(1, 32'h001081B3, 32'h54, 32'd3, 32'd3);
        out_ready = 0;
        repeat (3) begin
            step();
            chk("hold out_valid", out_valid, 1);
            chk("hold operand2", operand2, 32'hFFFFFFFF);
            chk("hold pc_out", pc_out, 32'h50);
        end
        flush = 1;
        step();
        chk("flush out_valid", out_valid, 0);

        // JAL, AUIPC, illegal opcode
        offer(1, 32'h000000EF, 32'h100, 32'd0, 32'd0);
        step();
        chk("jal operand1", operand1, 32'h100);
        chk("jal operand2", operand2, 32'd4);
        offer(1, 32'h12345117, 32'h200, 32'd0, 32'd0);
        step();
        chk("auipc operand2", operand2, 32'h12345000);
        offer(1, 32'h0000007F, 32'h204, 32'd0, 32'd0);
        step();
        chk("illegal flag", illegal, 1);

        // asynchronous reset between edges
        rst_n = 0;
        #1 chk("async reset out_valid", out_valid, 0);
        model_reset();
        #1 rst_n = 1;
        offer(0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();

        for (int i = 0; i < 3000; i++) begin
            instr = $urandom;
            instr[6:0]   = OPS[$urandom_range(0, 9)];
            if ($urandom_range(0, 2) == 0) instr[6:0] = 7'h03;
            instr[11:7]  = 5'($urandom_range(0, 3));
            instr[19:15] = 5'($urandom_range(0, 3));
            instr[24:20] = 5'($urandom_range(0, 3));
            in_valid  = ($urandom_range(0, 9) < 7);
            pc        = $urandom;
            reg1_data = $urandom;
            reg2_data = $urandom;
            exm_we    = 1'($urandom);
            exm_rd    = 5'($urandom_range(0, 3));
            exm_data  = $urandom;
            mwb_we    = 1'($urandom);
            mwb_rd    = 5'($urandom_range(0, 3));
            mwb_data  = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
